buf_exchange: RTL and testbench

- Shared inter-core buffer exchange for the multicore build.
- Sits directly downstream of each core's buffer register (buf_val_1, buf_val_2, buf_flag) and upstream of each core's memory-stage buffer reads (buf_val_*_addr to buf_val_*_select).
- Collects one 32-bit value pair per core per round into a write bank.
- When every core has deposited, it publishes the bank atomically, swapping double-buffered banks, and raises the all_buf_flags barrier to all cores.

---
 rtl/buf_exchange.sv | 109 ++++++++++
 tb/tb_buf_exchange.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/buf_exchange.sv
// Double-buffered inter-core exchange. Each core deposits one value pair per round.
// When all cores have deposited, the filled bank is swapped in and the barrier is raised.
module buf_exchange #(
  parameter int CORES = 4,
  parameter int DW    = 32
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [CORES*DW-1:0] core_buf_val_1,
  input  logic [CORES*DW-1:0] core_buf_val_2,
  input  logic [CORES-1:0]    core_buf_flag,
  input  logic [CORES*5-1:0]  core_addr_1,
  input  logic [CORES*5-1:0]  core_addr_2,
  output logic [CORES*DW-1:0] core_select_1,
  output logic [CORES*DW-1:0] core_select_2,
  output logic                all_buf_flags,
  output logic [7:0]          epoch,
  output logic [CORES-1:0]    overflow
);

  localparam int          NENT   = 2 * CORES;
  localparam logic [5:0]  NENT_L = 6'(NENT);

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] READY   = 1'b1;

  logic [0:0]         r_state;
  logic               r_rbank;
  logic [CORES-1:0]   r_flagQ;
  logic [CORES-1:0]   r_deposited;
  logic [CORES-1:0]   r_overflow;
  logic [7:0]         r_epoch;
  logic [NENT*DW-1:0] r_bank0;
  logic [NENT*DW-1:0] r_bank1;

  logic [CORES-1:0]   w_capture;
  logic [CORES-1:0]   w_accept;
  logic [CORES-1:0]   w_dup;
  logic               w_publish;
  logic [NENT*DW-1:0] w_pubBank;

  assign w_capture = core_buf_flag & ~r_flagQ;
  assign w_accept  = w_capture & ~r_deposited;
  assign w_dup     = w_capture & r_deposited;
  // A round completes when every core has either deposited already or deposits on this edge.
  assign w_publish = &(r_deposited | w_accept);

  // Deposits always land in the bank that is not currently published.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_flagQ     <= '0;
      r_deposited <= '0;
      r_overflow  <= '0;
      r_rbank     <= 1'b0;
      r_epoch     <= 8'd0;
      r_bank0     <= '0;
      r_bank1     <= '0;
    end else begin
      r_flagQ    <= core_buf_flag;
      r_overflow <= r_overflow | w_dup;
      for (int c = 0; c < CORES; c++) begin
        if (w_accept[c]) begin
          if (r_rbank) begin
            r_bank0[(2*c)*DW +: DW]   <= core_buf_val_1[c*DW +: DW];
            r_bank0[(2*c+1)*DW +: DW] <= core_buf_val_2[c*DW +: DW];
          end else begin
            r_bank1[(2*c)*DW +: DW]   <= core_buf_val_1[c*DW +: DW];
            r_bank1[(2*c+1)*DW +: DW] <= core_buf_val_2[c*DW +: DW];
          end
        end
      end
      if (w_publish) begin
        r_rbank     <= ~r_rbank;
        r_deposited <= '0;
        r_epoch     <= r_epoch + 8'd1;
      end else begin
        r_deposited <= r_deposited | w_accept;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= COLLECT;
    end else if (w_publish) begin
      r_state <= READY;
    end else if (r_state == READY && |w_accept) begin
      r_state <= COLLECT;
    end
  end

  assign w_pubBank     = r_rbank ? r_bank1 : r_bank0;
  assign all_buf_flags = (r_state == READY);
  assign epoch         = r_epoch;
  assign overflow      = r_overflow;

  // Out-of-range addresses read as zero.
  for (genvar c = 0; c < CORES; c++) begin : g_read
    logic [4:0] w_a1;
    logic [4:0] w_a2;
    assign w_a1 = core_addr_1[c*5 +: 5];
    assign w_a2 = core_addr_2[c*5 +: 5];
    assign core_select_1[c*DW +: DW] = ({1'b0, w_a1} < NENT_L) ?
                                       w_pubBank[int'(w_a1)*DW +: DW] : '0;
    assign core_select_2[c*DW +: DW] = ({1'b0, w_a2} < NENT_L) ?
                                       w_pubBank[int'(w_a2)*DW +: DW] : '0;
  end

endmodule

// File: tb/tb_buf_exchange.sv
// Directed self-checking bench for buf_exchange with four cores.
// Expected published contents are tracked in a small array set by the test sequence.
module tb_buf_exchange;

  localparam int CORES = 4;
  localparam int DW    = 32;

  logic                Clk = 1'b0;
  logic                Reset;
  logic [CORES*DW-1:0] coreBufVal1;
  logic [CORES*DW-1:0] coreBufVal2;
  logic [CORES-1:0]    coreBufFlag;
  logic [CORES*5-1:0]  coreAddr1;
  logic [CORES*5-1:0]  coreAddr2;
  logic [CORES*DW-1:0] coreSelect1;
  logic [CORES*DW-1:0] coreSelect2;
  logic                allBufFlags;
  logic [7:0]          epoch;
  logic [CORES-1:0]    overflow;

  int errorCount = 0;
  int checkCount = 0;
  logic [31:0] expPub [0:7];

  buf_exchange #(.CORES(CORES), .DW(DW)) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .core_buf_val_1 (coreBufVal1),
    .core_buf_val_2 (coreBufVal2),
    .core_buf_flag  (coreBufFlag),
    .core_addr_1    (coreAddr1),
    .core_addr_2    (coreAddr2),
    .core_select_1  (coreSelect1),
    .core_select_2  (coreSelect2),
    .all_buf_flags  (allBufFlags),
    .epoch          (epoch),
    .overflow       (overflow)
  );

  // Free-running clock, period 10.
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Raise the masked flags for one edge with value base+c per core, then drop them for one edge.
  task automatic applyStimulus(input logic [3:0] mask, input logic [31:0] base1, input logic [31:0] base2);
    for (int c = 0; c < CORES; c++) begin
      coreBufVal1[c*DW +: DW] = base1 + 32'(c);
      coreBufVal2[c*DW +: DW] = base2 + 32'(c);
    end
    coreBufFlag = mask;
    tick();
    coreBufFlag = '0;
    tick();
  endtask

  // Read one address through port 1 of one core and port 2 of another.
  task automatic checkRead(input string tag, input int addr, input logic [31:0] expected);
    int c1;
    int c2;
    c1 = addr % CORES;
    c2 = CORES - 1 - c1;
    coreAddr1[c1*5 +: 5] = 5'(addr);
    coreAddr2[c2*5 +: 5] = 5'(addr);
    #1;
    checkOutput({tag, "_p1"}, coreSelect1[c1*DW +: DW], expected);
    checkOutput({tag, "_p2"}, coreSelect2[c2*DW +: DW], expected);
  endtask

  task automatic checkBank(input string tag);
    for (int a = 0; a < 8; a++) checkRead($sformatf("%s_a%0d", tag, a), a, expPub[a]);
  endtask

  task automatic setExpected(input logic [31:0] base1, input logic [31:0] base2);
    for (int c = 0; c < CORES; c++) begin
      expPub[2*c]   = base1 + 32'(c);
      expPub[2*c+1] = base2 + 32'(c);
    end
  endtask

  initial begin
    Reset       = 1'b1;
    coreBufVal1 = '0;
    coreBufVal2 = '0;
    coreBufFlag = '0;
    coreAddr1   = '0;
    coreAddr2   = '0;
    for (int a = 0; a < 8; a++) expPub[a] = 32'd0;
    #12;
    Reset = 1'b0;
    tick();

    // Reset state: every address reads zero.
    for (int a = 0; a < 32; a++) checkRead($sformatf("rst_a%0d", a), a, 32'd0);
    checkOutput("rst_flags", 32'(allBufFlags), 32'd0);
    checkOutput("rst_epoch", 32'(epoch), 32'd0);
    checkOutput("rst_ovf", 32'(overflow), 32'd0);

    // Round 1: one core per cycle.
    for (int c = 0; c < CORES; c++) begin
      applyStimulus(4'(1 << c), 32'h100, 32'h200);
      if (c < CORES - 1) checkOutput($sformatf("r1_flags_c%0d", c), 32'(allBufFlags), 32'd0);
      if (c < CORES - 1) checkOutput($sformatf("r1_epoch_c%0d", c), 32'(epoch), 32'd0);
    end
    checkOutput("r1_flags", 32'(allBufFlags), 32'd1);
    checkOutput("r1_epoch", 32'(epoch), 32'd1);
    checkRead("r1_a5", 5, 32'h202);
    checkRead("r1_a6", 6, 32'h103);
    checkRead("r1_a9", 9, 32'd0);
    setExpected(32'h100, 32'h200);
    checkBank("r1");

    // Round 2: published data holds until the last core deposits.
    applyStimulus(4'b0001, 32'hAAAA, 32'hBBBB);
    checkOutput("r2_flags_fall", 32'(allBufFlags), 32'd0);
    checkRead("r2_a0_hold", 0, 32'h100);
    applyStimulus(4'b0010, 32'h300, 32'h400);
    applyStimulus(4'b0100, 32'h300, 32'h400);
    checkRead("r2_a0_hold2", 0, 32'h100);
    checkOutput("r2_epoch_hold", 32'(epoch), 32'd1);
    applyStimulus(4'b1000, 32'h300, 32'h400);
    checkOutput("r2_flags", 32'(allBufFlags), 32'd1);
    checkOutput("r2_epoch", 32'(epoch), 32'd2);
    setExpected(32'h300, 32'h400);
    expPub[0] = 32'hAAAA;
    expPub[1] = 32'hBBBB;
    checkBank("r2");

    // Round 3: core 1 deposits twice, the second is dropped.
    applyStimulus(4'b0010, 32'h510, 32'h610);
    applyStimulus(4'b0010, 32'h998, 32'h997);
    checkOutput("r3_ovf", 32'(overflow), 32'h2);
    checkOutput("r3_flags", 32'(allBufFlags), 32'd0);
    applyStimulus(4'b1101, 32'h500, 32'h600);
    checkOutput("r3_epoch", 32'(epoch), 32'd3);
    checkOutput("r3_flags_up", 32'(allBufFlags), 32'd1);
    setExpected(32'h500, 32'h600);
    expPub[2] = 32'h511;
    expPub[3] = 32'h611;
    checkBank("r3");

    // Round 4: all cores on one edge produce a single publish.
    applyStimulus(4'hF, 32'h700, 32'h800);
    checkOutput("r4_epoch", 32'(epoch), 32'd4);
    checkOutput("r4_flags", 32'(allBufFlags), 32'd1);
    checkOutput("r4_ovf", 32'(overflow), 32'h2);
    setExpected(32'h700, 32'h800);
    checkBank("r4");

    // Mid-round reset after two deposits.
    applyStimulus(4'b0001, 32'hC00, 32'hD00);
    applyStimulus(4'b0010, 32'hC00, 32'hD00);
    checkOutput("mr_flags_pre", 32'(allBufFlags), 32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    checkOutput("mr_flags", 32'(allBufFlags), 32'd0);
    checkOutput("mr_epoch", 32'(epoch), 32'd0);
    checkOutput("mr_ovf", 32'(overflow), 32'd0);
    for (int a = 0; a < 8; a++) expPub[a] = 32'd0;
    checkBank("mr");
    @(negedge Clk);
    Reset = 1'b0;
    tick();
    applyStimulus(4'b0011, 32'hE00, 32'hF00);
    checkOutput("pr_flags_mid", 32'(allBufFlags), 32'd0);
    applyStimulus(4'b1100, 32'hE00, 32'hF00);
    checkOutput("pr_epoch", 32'(epoch), 32'd1);
    checkOutput("pr_flags", 32'(allBufFlags), 32'd1);
    setExpected(32'hE00, 32'hF00);
    checkBank("pr");

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
